// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE samples, ACCESS drives memory and pulses gnt, RESP pulses rvalid.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.
module dmem_arbiter #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_0,
  input  logic                 req_1,
  input  logic                 we_0,
  input  logic                 we_1,
  input  logic [2:0]           funct3_0,
  input  logic [2:0]           funct3_1,
  input  logic [BIT_WIDTH-1:0] addr_0,
  input  logic [BIT_WIDTH-1:0] addr_1,
  input  logic [BIT_WIDTH-1:0] wdata_0,
  input  logic [BIT_WIDTH-1:0] wdata_1,
  output logic                 gnt_0,
  output logic                 gnt_1,
  output logic                 rvalid_0,
  output logic                 rvalid_1,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic                 rerr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [2:0]           mem_funct3,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]           state;
  logic                 winner;
  logic                 pick;
  logic                 txn_we;
  logic                 txn_fault;
  logic [2:0]           txn_funct3;
  logic [BIT_WIDTH-1:0] txn_addr;
  logic [BIT_WIDTH-1:0] txn_wdata;

  logic                 sel_we;
  logic [2:0]           sel_funct3;
  logic [BIT_WIDTH-1:0] sel_addr;
  logic [BIT_WIDTH-1:0] sel_wdata;
  logic                 in_access;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_gnt <= 1'b1;
    else if (state == IDLE && (req_0 || req_1))
      last_gnt <= pick;
  end

  assign pick = (req_0 && req_1) ? ~last_gnt : ~req_0;
`else
  assign pick = ~req_0;
`endif

  assign sel_we     = pick ? we_1     : we_0;
  assign sel_funct3 = pick ? funct3_1 : funct3_0;
  assign sel_addr   = pick ? addr_1   : addr_0;
  assign sel_wdata  = pick ? wdata_1  : wdata_0;

  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_op;
    logic misaligned;
    if (we)
      bad_op = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    else
      bad_op = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a != 2'b00));
    return bad_op || misaligned;
  endfunction

  // Fault is decided at sampling time so ACCESS only has to gate the strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      winner     <= 1'b0;
      txn_we     <= 1'b0;
      txn_fault  <= 1'b0;
      txn_funct3 <= '0;
      txn_addr   <= '0;
      txn_wdata  <= '0;
      rdata      <= '0;
      rerr       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_0 || req_1) begin
            winner     <= pick;
            txn_we     <= sel_we;
            txn_funct3 <= sel_funct3;
            txn_addr   <= sel_addr;
            txn_wdata  <= sel_wdata;
            txn_fault  <= is_fault(sel_we, sel_funct3, sel_addr[1:0]);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rdata <= (txn_we || txn_fault) ? '0 : mem_rdata;
          rerr  <= txn_fault;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access  = (state == ACCESS);
  assign gnt_0      = in_access && !winner;
  assign gnt_1      = in_access && winner;
  assign rvalid_0   = (state == RESP) && !winner;
  assign rvalid_1   = (state == RESP) && winner;
  assign mem_read   = in_access && !txn_fault && !txn_we;
  assign mem_write  = in_access && !txn_fault && txn_we;
  assign mem_funct3 = in_access ? txn_funct3 : 3'b000;
  assign mem_addr   = in_access ? txn_addr : '0;
  assign mem_wdata  = in_access ? txn_wdata : '0;

endmodule
